mips_boot_loader: RTL and testbench

MIPS_BOOT_LOADER -- requirements
Module: mips_boot_loader

---
 rtl/mips_boot_loader.sv | 183 ++++++++++++++++++
 tb/tb_mips_boot_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_boot_loader.sv
// Boot loader: holds the CPU in reset, streams instruction and data words
// into the exported memories, then runs the CPU for a bounded cycle count.
// Ports:
//   clk, rst (async, active-low)
//   start, abort: control
//   inst_count, data_count, run_cycles: job size
//   src_valid/src_ready/src_data: word stream in
//   cpu_rst, enPC: CPU control
//   instmem_export_*, datamem_export_*: memory write/read ports
//   busy, done: status
module mips_boot_loader #(
  parameter int IADDR_W     = 7,
  parameter int DADDR_W     = 11,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [IADDR_W:0]   inst_count,
  input  logic [DADDR_W:0]   data_count,
  input  logic [15:0]        run_cycles,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [31:0]        src_data,
  output logic               cpu_rst,
  output logic               enPC,
  output logic [IADDR_W-1:0] instmem_export_address,
  output logic [31:0]        instmem_export_data,
  output logic               instmem_export_MW,
  output logic               instmem_export_MR,
  output logic [DADDR_W-1:0] datamem_export_address,
  output logic [15:0]        datamem_export_data,
  output logic               datamem_export_MW,
  output logic               datamem_export_MR,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    LOAD_I,
    LOAD_D,
    RUN,
    DONE
  } state_t;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t             state;
  logic [HW-1:0]      hold_cnt;
  logic [IADDR_W:0]   inst_n;
  logic [DADDR_W:0]   data_n;
  logic [15:0]        run_n;
  logic [IADDR_W:0]   inst_ptr;
  logic [DADDR_W:0]   data_ptr;
  logic [15:0]        run_cnt;

  logic [IADDR_W:0]   inst_nxt;
  logic [DADDR_W:0]   data_nxt;
  logic [15:0]        run_nxt;

  // Pointers are one bit wider than the address so a full
  // 2^W load terminates without wrapping.
  assign inst_nxt = inst_ptr + 1'b1;
  assign data_nxt = data_ptr + 1'b1;
  assign run_nxt  = run_cnt + 16'd1;

  assign src_ready = (state == LOAD_I) || (state == LOAD_D);
  assign busy      = !((state == IDLE) || (state == DONE));
  assign done      = (state == DONE);
  assign instmem_export_MR = !busy;
  assign datamem_export_MR = !busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                  <= IDLE;
      hold_cnt               <= '0;
      inst_n                 <= '0;
      data_n                 <= '0;
      run_n                  <= '0;
      inst_ptr               <= '0;
      data_ptr               <= '0;
      run_cnt                <= '0;
      cpu_rst                <= 1'b1;
      enPC                   <= 1'b0;
      instmem_export_address <= '0;
      instmem_export_data    <= '0;
      instmem_export_MW      <= 1'b0;
      datamem_export_address <= '0;
      datamem_export_data    <= '0;
      datamem_export_MW      <= 1'b0;
    end else begin
      instmem_export_MW <= 1'b0;
      datamem_export_MW <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        cpu_rst <= 1'b1;
        enPC    <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (start) begin
              inst_n                 <= inst_count;
              data_n                 <= data_count;
              run_n                  <= run_cycles;
              inst_ptr               <= '0;
              data_ptr               <= '0;
              run_cnt                <= '0;
              hold_cnt               <= '0;
              instmem_export_address <= '0;
              datamem_export_address <= '0;
              cpu_rst                <= 1'b1;
              enPC                   <= 1'b0;
              state                  <= HOLD;
            end
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              if (inst_n != '0) begin
                state <= LOAD_I;
              end else if (data_n != '0) begin
                state <= LOAD_D;
              end else begin
                state   <= RUN;
                cpu_rst <= 1'b0;
                enPC    <= 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          LOAD_I: begin
            if (src_valid) begin
              instmem_export_address <= inst_ptr[IADDR_W-1:0];
              instmem_export_data    <= src_data;
              instmem_export_MW      <= 1'b1;
              inst_ptr               <= inst_nxt;
              if (inst_nxt == inst_n) begin
                if (data_n != '0) begin
                  state <= LOAD_D;
                end else begin
                  state   <= RUN;
                  cpu_rst <= 1'b0;
                  enPC    <= 1'b1;
                end
              end
            end
          end
          LOAD_D: begin
            if (src_valid) begin
              datamem_export_address <= data_ptr[DADDR_W-1:0];
              datamem_export_data    <= src_data[15:0];
              datamem_export_MW      <= 1'b1;
              data_ptr               <= data_nxt;
              if (data_nxt == data_n) begin
                state   <= RUN;
                cpu_rst <= 1'b0;
                enPC    <= 1'b1;
              end
            end
          end
          RUN: begin
            // run_n == 0 means run until abort; the guard keeps a
            // wrapped counter from matching it.
            if ((run_n != 16'd0) && (run_nxt == run_n)) begin
              state <= DONE;
              enPC  <= 1'b0;
            end else begin
              run_cnt <= run_nxt;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: vector table of load/run
// jobs plus abort, reset-in-run and endless-run sequences.
module tb_mips_boot_loader;

  localparam int IW = 7;
  localparam int DW = 11;
  localparam int HC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [IW:0]   inst_count = '0;
  logic [DW:0]   data_count = '0;
  logic [15:0]   run_cycles = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [31:0]   src_data = '0;
  logic          cpu_rst;
  logic          enPC;
  logic [IW-1:0] i_addr;
  logic [31:0]   i_data;
  logic          i_mw;
  logic          i_mr;
  logic [DW-1:0] d_addr;
  logic [15:0]   d_data;
  logic          d_mw;
  logic          d_mr;
  logic          busy;
  logic          done;

  mips_boot_loader #(
    .IADDR_W(IW),
    .DADDR_W(DW),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .inst_count(inst_count),
    .data_count(data_count),
    .run_cycles(run_cycles),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_data(src_data),
    .cpu_rst(cpu_rst),
    .enPC(enPC),
    .instmem_export_address(i_addr),
    .instmem_export_data(i_data),
    .instmem_export_MW(i_mw),
    .instmem_export_MR(i_mr),
    .datamem_export_address(d_addr),
    .datamem_export_data(d_data),
    .datamem_export_MW(d_mw),
    .datamem_export_MR(d_mr),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ic;
    int dc;
    int rc;
    bit tog;
    int exp_mw;
  } vec_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t iq[$];
  wr_t dq[$];
  vec_t vt[6];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idx = 0;
  int ic_cur = 0;
  int abort_at = -1;
  int abort_cyc = 0;
  int en_cnt = 0;
  int hold_cnt = 0;
  int mw_cnt = 0;
  bit src_on = 0;
  bit tog = 0;
  bit abort_req = 0;
  bit acc = 0;

  function automatic logic [31:0] iword(int j);
    return 32'hC0DE_0000 ^ (32'(j) * 32'h0101_0037);
  endfunction

  function automatic logic [31:0] dword(int k);
    return {16'hBEEF, 16'(16'h4000 + k)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (acc) idx++;
    if (!busy) idx = 0;
    if (i_mw) begin
      mw_cnt++;
      if (iq.size() == 0) begin
        chk("imw_extra", 32'(i_addr), 32'hFFFF_FFFF);
      end else begin
        e = iq.pop_front();
        chk("imw_addr", 32'(i_addr), 32'(e.addr));
        chk("imw_data", i_data, e.data);
      end
    end
    if (d_mw) begin
      mw_cnt++;
      if (dq.size() == 0) begin
        chk("dmw_extra", 32'(d_addr), 32'hFFFF_FFFF);
      end else begin
        e = dq.pop_front();
        chk("dmw_addr", 32'(d_addr), 32'(e.addr));
        chk("dmw_data", 32'(d_data), e.data);
      end
    end
    if (enPC) en_cnt++;
    if (busy && cpu_rst && !src_ready && !enPC) hold_cnt++;
    src_valid = src_on && (!tog || cyc[0]);
    src_data = (idx < ic_cur) ? iword(idx) : dword(idx - ic_cur);
    abort = abort_req ||
            (abort_at == idx && src_valid && src_ready);
    if (abort && !abort_req) abort_cyc = cyc;
    acc = src_valid && src_ready && !abort;
  endtask

  task automatic push_job(int ic, int dc);
    wr_t e;
    for (int j = 0; j < ic; j++) begin
      e.addr = j;
      e.data = iword(j);
      iq.push_back(e);
    end
    for (int k = 0; k < dc; k++) begin
      e.addr = k;
      e.data = {16'h0, dword(k) & 32'hFFFF};
      dq.push_back(e);
    end
  endtask

  task automatic kick(int ic, int dc, int rc, bit tg);
    ic_cur = ic;
    inst_count = (IW+1)'(ic);
    data_count = (DW+1)'(dc);
    run_cycles = 16'(rc);
    src_on = 1;
    tog = tg;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(vec_t v);
    int h0, e0, m0;
    push_job(v.ic, v.dc);
    h0 = hold_cnt;
    e0 = en_cnt;
    m0 = mw_cnt;
    kick(v.ic, v.dc, v.rc, v.tog);
    chk("busy_after_start", 32'(busy), 1);
    chk("done_drops", 32'(done), 0);
    for (int i = 0; i < 2000 && !done; i++) tick();
    chk("done_reached", 32'(done), 1);
    chk("hold_cycles", 32'(hold_cnt - h0), HC);
    chk("en_cycles", 32'(en_cnt - e0), 32'(v.rc));
    chk("mw_pulses", 32'(mw_cnt - m0), 32'(v.exp_mw));
    chk("iq_left", 32'(iq.size()), 0);
    chk("dq_left", 32'(dq.size()), 0);
    chk("done_cpu_rst", 32'(cpu_rst), 0);
    chk("done_enpc", 32'(enPC), 0);
    chk("done_mr", 32'({i_mr, d_mr}), 3);
    src_on = 0;
  endtask

  initial begin
    int en_low;
    vt[0] = '{ic: 3,   dc: 2, rc: 16, tog: 0, exp_mw: 5};
    vt[1] = '{ic: 4,   dc: 0, rc: 3,  tog: 1, exp_mw: 4};
    vt[2] = '{ic: 0,   dc: 0, rc: 5,  tog: 0, exp_mw: 0};
    vt[3] = '{ic: 0,   dc: 3, rc: 1,  tog: 1, exp_mw: 3};
    vt[4] = '{ic: 128, dc: 2, rc: 2,  tog: 0, exp_mw: 130};
    vt[5] = '{ic: 1,   dc: 1, rc: 7,  tog: 1, exp_mw: 2};

    tick();
    tick();
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_enpc", 32'(enPC), 0);
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_mw", 32'({i_mw, d_mw}), 0);
    chk("rst_mr", 32'({i_mr, d_mr}), 3);
    chk("rst_busy_done", 32'({busy, done}), 0);
    chk("rst_addr", 32'({i_addr, d_addr}), 0);
    chk("rst_data", 32'(i_data | 32'(d_data)), 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    for (int v = 0; v < 6; v++) run_vec(vt[v]);

    // abort on the accept cycle of inst word 2
    push_job(2, 0);
    abort_at = 2;
    kick(4, 2, 3, 0);
    for (int i = 0; i < 100 && busy; i++) tick();
    chk("abort_idle", 32'(busy), 0);
    chk("abort_latency", 32'(cyc - abort_cyc), 1);
    chk("abort_cpu_rst", 32'(cpu_rst), 1);
    chk("abort_enpc", 32'(enPC), 0);
    chk("abort_done", 32'(done), 0);
    abort_at = -1;
    src_on = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_iq_left", 32'(iq.size()), 1'b0);

    // asynchronous reset while running
    push_job(1, 1);
    kick(1, 1, 0, 0);
    for (int i = 0; i < 200 && !enPC; i++) tick();
    chk("run_enpc", 32'(enPC), 1);
    src_on = 0;
    #2 rst = 1'b0;
    #1;
    chk("arst_enpc", 32'(enPC), 0);
    chk("arst_cpu_rst", 32'(cpu_rst), 1);
    chk("arst_busy", 32'(busy), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("arst_idle", 32'({busy, done}), 0);
    chk("arst_iq", 32'(iq.size() + dq.size()), 0);
    run_vec('{ic: 2, dc: 1, rc: 3, tog: 0, exp_mw: 3});

    // endless run, start ignored, then abort
    kick(0, 0, 0, 0);
    src_on = 0;
    for (int i = 0; i < 50 && !enPC; i++) tick();
    en_low = 0;
    for (int i = 0; i < 120; i++) begin
      start = (i % 7 == 0);
      tick();
      if (!enPC || !busy) en_low++;
    end
    start = 1'b0;
    chk("endless_enpc", 32'(en_low), 0);
    abort_req = 1;
    tick();
    abort_req = 0;
    tick();
    chk("endless_abort_busy", 32'(busy), 0);
    chk("endless_abort_enpc", 32'(enPC), 0);
    chk("endless_abort_rst", 32'(cpu_rst), 1);
    chk("endless_mw", 32'(iq.size() + dq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
